// File: rtl/riscy_pkg.sv
// Shared definitions for the riscy core: opcode map, writeback/memory encodings, widths.
package riscy_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned XLEN   = 32;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2,
        WbImm = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } mem_size_e;

endpackage

// File: rtl/pc.sv
// Program counter register: async active-low clear, load on jump, else step by 4.
module pc #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_en,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] out_addr
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (jump_en) begin
            pc_d = in_addr;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out_addr = pc_q;

endmodule

// File: rtl/ctrl.sv
// RV32I control unit: combinational instruction decode plus next-pc target selection.
module ctrl
    import riscy_pkg::*;
#(
    parameter int unsigned ADDR_W = riscy_pkg::ADDR_W,
    parameter int unsigned XLEN   = riscy_pkg::XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   inst,
    input  logic [XLEN-1:0]   r1_val,
    input  logic              br_taken,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [XLEN-1:0]   imm,
    output logic [4:0]        rd_addr,
    output logic [4:0]        r1_addr,
    output logic [4:0]        r2_addr,
    output logic              rf_w_en,
    output logic [1:0]        wb_sel,
    output logic              alu_src,
    output logic              alu_pc,
    output logic [3:0]        alu_op,
    output logic              mem_w_en,
    output logic              mem_u_en,
    output logic [1:0]        mem_size,
    output logic              illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
    logic              wr_en;
    logic              alu_alt;
    wb_sel_e           wb;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              unused_r1_hi;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rd_addr = inst[11:7];
    assign r1_addr = inst[19:15];
    assign r2_addr = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Only pc-sized bits of the JALR base matter; targets wrap within the address space.
    assign unused_r1_hi = ^r1_val[XLEN-1:ADDR_W];

    always_comb begin
        imm         = '0;
        wr_en       = 1'b0;
        wb          = WbAlu;
        alu_src     = 1'b0;
        alu_pc      = 1'b0;
        mem_w_en    = 1'b0;
        illegal     = 1'b0;
        jump_en     = 1'b0;
        jump_target = '0;
        unique case (opcode)
            OpcLui: begin
                imm     = imm_u;
                wr_en   = 1'b1;
                wb      = WbImm;
                alu_src = 1'b1;
            end
            OpcAuipc: begin
                imm     = imm_u;
                wr_en   = 1'b1;
                alu_src = 1'b1;
                alu_pc  = 1'b1;
            end
            OpcJal: begin
                imm         = imm_j;
                wr_en       = 1'b1;
                wb          = WbPc4;
                jump_en     = 1'b1;
                jump_target = pc_addr + imm_j[ADDR_W-1:0];
            end
            OpcJalr: begin
                imm         = imm_i;
                wr_en       = 1'b1;
                wb          = WbPc4;
                alu_src     = 1'b1;
                jump_en     = 1'b1;
                jump_target = (r1_val[ADDR_W-1:0] + imm_i[ADDR_W-1:0])
                            & {{(ADDR_W-1){1'b1}}, 1'b0};
            end
            OpcBranch: begin
                imm         = imm_b;
                jump_en     = br_taken;
                jump_target = pc_addr + imm_b[ADDR_W-1:0];
            end
            OpcLoad: begin
                imm     = imm_i;
                wr_en   = 1'b1;
                wb      = WbMem;
                alu_src = 1'b1;
            end
            OpcStore: begin
                imm      = imm_s;
                mem_w_en = 1'b1;
                alu_src  = 1'b1;
            end
            OpcOpImm: begin
                imm     = imm_i;
                wr_en   = 1'b1;
                alu_src = 1'b1;
            end
            OpcOp: begin
                wr_en = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // inst[30] selects SUB/SRA; only meaningful for R-type and immediate shifts.
    assign alu_alt = inst[30] & ((opcode == OpcOp) ||
                                 ((opcode == OpcOpImm) && (funct3[1:0] == 2'b01)));
    assign alu_op  = {alu_alt, funct3};

    assign rf_w_en  = wr_en & (rd_addr != 5'd0) & ~illegal;
    assign wb_sel   = wb;
    assign mem_u_en = funct3[2];
    assign mem_size = funct3[1:0];

    pc #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .jump_en (jump_en),
        .inc_en  (1'b1),
        .in_addr (jump_target),
        .out_addr(pc_addr)
    );

endmodule

// File: tb/tb_ctrl.sv
// Directed and randomized checks of ctrl decode and pc sequencing against an arithmetic model.
module tb_ctrl;

    localparam int          ADDR_W = 14;
    localparam int          PC_MASK = (1 << ADDR_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       inst, r1_val;
    logic              br_taken;
    logic [ADDR_W-1:0] pc_addr;
    logic [31:0]       imm;
    logic [4:0]        rd_addr, r1_addr, r2_addr;
    logic              rf_w_en, alu_src, alu_pc, mem_w_en, mem_u_en, illegal;
    logic [1:0]        wb_sel, mem_size;
    logic [3:0]        alu_op;

    always #5 clk = ~clk;

    ctrl u_dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst),
        .r1_val  (r1_val),
        .br_taken(br_taken),
        .pc_addr (pc_addr),
        .imm     (imm),
        .rd_addr (rd_addr),
        .r1_addr (r1_addr),
        .r2_addr (r2_addr),
        .rf_w_en (rf_w_en),
        .wb_sel  (wb_sel),
        .alu_src (alu_src),
        .alu_pc  (alu_pc),
        .alu_op  (alu_op),
        .mem_w_en(mem_w_en),
        .mem_u_en(mem_u_en),
        .mem_size(mem_size),
        .illegal (illegal)
    );

    int n_cmp = 0;
    int n_err = 0;
    int model_pc;
    int exp_next;

    typedef struct {
        logic [31:0] imm;
        bit          imm_known;
        bit          rf_w;
        logic [1:0]  wb;
        bit          wb_known;
        bit          alu_src;
        bit          src_known;
        bit          alu_pc;
        bit          mem_w;
        bit          illegal;
        logic [3:0]  alu_op;
    } exp_t;

    logic [6:0] legal_opc [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] opc);
        for (int k = 0; k < 9; k++) if (legal_opc[k] == opc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int imm_i_of(input logic [31:0] w);
        int v = w[31:20];
        if (w[31]) v -= 4096;
        return v;
    endfunction

    function automatic int imm_s_of(input logic [31:0] w);
        int v = w[31:25] * 32 + w[11:7];
        if (w[31]) v -= 4096;
        return v;
    endfunction

    function automatic int imm_b_of(input logic [31:0] w);
        int v = w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
        if (w[31]) v -= 4096;
        return v;
    endfunction

    function automatic int imm_j_of(input logic [31:0] w);
        int v = w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
        if (w[31]) v -= (1 << 20);
        return v;
    endfunction

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t e = '{imm: 32'h0, imm_known: 0, rf_w: 0, wb: 2'd0, wb_known: 0, alu_src: 0,
                    src_known: 0, alu_pc: 0, mem_w: 0, illegal: 0, alu_op: 4'h0};
        logic [2:0] f3 = w[14:12];
        bit shift = (f3 == 3'd1) || (f3 == 3'd5);
        case (w[6:0])
            7'h37: begin e.imm = {w[31:12], 12'h000}; e.imm_known = 1; e.rf_w = 1;
                         e.wb = 3; e.wb_known = 1; end
            7'h17: begin e.imm = {w[31:12], 12'h000}; e.imm_known = 1; e.rf_w = 1;
                         e.wb = 0; e.wb_known = 1; e.alu_src = 1; e.src_known = 1;
                         e.alu_pc = 1; end
            7'h6F: begin e.imm = imm_j_of(w); e.imm_known = 1; e.rf_w = 1;
                         e.wb = 2; e.wb_known = 1; end
            7'h67: begin e.imm = imm_i_of(w); e.imm_known = 1; e.rf_w = 1;
                         e.wb = 2; e.wb_known = 1; end
            7'h63: begin e.imm = imm_b_of(w); e.imm_known = 1; e.src_known = 1; end
            7'h03: begin e.imm = imm_i_of(w); e.imm_known = 1; e.rf_w = 1; e.wb = 1;
                         e.wb_known = 1; e.alu_src = 1; e.src_known = 1; end
            7'h23: begin e.imm = imm_s_of(w); e.imm_known = 1; e.mem_w = 1;
                         e.alu_src = 1; e.src_known = 1; end
            7'h13: begin e.imm = imm_i_of(w); e.imm_known = 1; e.rf_w = 1; e.wb = 0;
                         e.wb_known = 1; e.alu_src = 1; e.src_known = 1; end
            7'h33: begin e.rf_w = 1; e.wb = 0; e.wb_known = 1; e.src_known = 1; end
            default: e.illegal = 1;
        endcase
        if (w[11:7] == 5'd0) e.rf_w = 0;
        e.alu_op = {((w[6:0] == 7'h33) || (w[6:0] == 7'h13 && shift)) ? w[30] : 1'b0, f3};
        return e;
    endfunction

    function automatic int model_next(input int cur, input logic [31:0] w,
                                      input logic [31:0] r1, input logic br);
        case (w[6:0])
            7'h6F:   return (cur + imm_j_of(w)) & PC_MASK;
            7'h67:   return (int'(r1) + imm_i_of(w)) & PC_MASK & ~1;
            7'h63:   return br ? ((cur + imm_b_of(w)) & PC_MASK) : ((cur + 4) & PC_MASK);
            default: return (cur + 4) & PC_MASK;
        endcase
    endfunction

    task automatic check_decode();
        exp_t e = model_decode(inst);
        chk("rd_addr", {27'h0, rd_addr}, {27'h0, inst[11:7]});
        chk("r1_addr", {27'h0, r1_addr}, {27'h0, inst[19:15]});
        chk("r2_addr", {27'h0, r2_addr}, {27'h0, inst[24:20]});
        chk("illegal", {31'h0, illegal}, {31'h0, e.illegal});
        chk("rf_w_en", {31'h0, rf_w_en}, {31'h0, e.rf_w});
        chk("mem_w_en", {31'h0, mem_w_en}, {31'h0, e.mem_w});
        chk("alu_pc", {31'h0, alu_pc}, {31'h0, e.alu_pc});
        chk("alu_op", {28'h0, alu_op}, {28'h0, e.alu_op});
        chk("mem_u_en", {31'h0, mem_u_en}, {31'h0, inst[14]});
        chk("mem_size", {30'h0, mem_size}, {30'h0, inst[13:12]});
        if (e.imm_known) chk("imm", imm, e.imm);
        if (e.wb_known) chk("wb_sel", {30'h0, wb_sel}, {30'h0, e.wb});
        if (e.src_known) chk("alu_src", {31'h0, alu_src}, {31'h0, e.alu_src});
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] r1, input logic br);
        @(negedge clk);
        inst = w;
        r1_val = r1;
        br_taken = br;
        #1;
        check_decode();
        chk("pc_hold", {18'h0, pc_addr}, model_pc);
        exp_next = model_next(model_pc, w, r1, br);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_pc = exp_next;
        chk("pc_step", {18'h0, pc_addr}, model_pc);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 9) begin
            w[6:0] = legal_opc[k];
        end else if (is_legal(w[6:0])) begin
            w[6:0] = 7'h7F;
        end
        return w;
    endfunction

    initial begin
        reset = 1'b0;
        inst = NOP;
        r1_val = 32'h0;
        br_taken = 1'b0;
        model_pc = 0;
        exp_next = 0;
        #3;
        chk("reset_pc", {18'h0, pc_addr}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_hold", {18'h0, pc_addr}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 2; i++) begin
            drive(NOP, 32'h0, 1'b0);
            chk("nop_pc", {18'h0, pc_addr}, 32'(4 * i));
            tick();
        end

        // JAL x6 at pc 8: J-imm fields give 0x7FFE, target wraps to 0x0006
        drive(32'h7FF0_736F, 32'h0, 1'b0);
        chk("jal_imm", imm, 32'h0000_7FFE);
        chk("jal_wb", {30'h0, wb_sel}, 32'd2);
        chk("jal_rd", {27'h0, rd_addr}, 32'd6);
        tick();
        chk("jal_pc", {18'h0, pc_addr}, 32'h0006);

        drive(32'hFFFF_F0B7, 32'h0, 1'b0);
        chk("lui_imm", imm, 32'hFFFF_F000);
        chk("lui_rd", {27'h0, rd_addr}, 32'd1);
        chk("lui_wen", {31'h0, rf_w_en}, 32'd1);
        chk("lui_wb", {30'h0, wb_sel}, 32'd3);
        tick();

        drive(32'hFFFF_F297, 32'h0, 1'b0);
        chk("auipc_imm", imm, 32'hFFFF_F000);
        chk("auipc_rd", {27'h0, rd_addr}, 32'd5);
        chk("auipc_pc", {31'h0, alu_pc}, 32'd1);
        chk("auipc_wb", {30'h0, wb_sel}, 32'd0);
        tick();

        drive(32'h0003_0083, 32'h0, 1'b0);
        chk("lb_r1", {27'h0, r1_addr}, 32'd6);
        chk("lb_size", {30'h0, mem_size}, 32'd0);
        chk("lb_u", {31'h0, mem_u_en}, 32'd0);
        chk("lb_wb", {30'h0, wb_sel}, 32'd1);
        tick();

        drive(32'h0000_8067, 32'h0000_0103, 1'b0);
        tick();
        chk("jalr_bit1", {18'h0, pc_addr}, 32'h0102);

        drive(32'h0000_8067, 32'h0000_3FFC, 1'b0);
        tick();
        chk("pc_top", {18'h0, pc_addr}, 32'h3FFC);
        drive(NOP, 32'h0, 1'b0);
        tick();
        chk("pc_wrap", {18'h0, pc_addr}, 32'h0);

        drive(32'h0000_8067, 32'h0000_0040, 1'b0);
        tick();
        chk("pc_0x40", {18'h0, pc_addr}, 32'h40);
        drive(NOP, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_reset", {18'h0, pc_addr}, 32'h0);
        model_pc = 0;
        @(posedge clk);
        #1;
        chk("midrun_hold", {18'h0, pc_addr}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 500; i++) begin
            drive(rand_inst(), $urandom, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
